reg_bus_split: RTL
==================

Name: reg_bus_split

Overview:
- Parametrised 1-to-N register-bus splitter.
- Decodes one upstream REG_BUS-style master port onto P_NUM_SLV downstream slave ports.
- Adds a read-response timeout, unmapped-address handling, a busy indication and sticky error flags, none of which the plain register bus provides.
- Sits between the local-bus/SPI bridge and the per-function register banks (DDR test, ADC/DAC config, AWG control).

Parameters:
- P_ADDR_WIDTH, 16: upstream address width.
- P_SLV_AWIDTH, 12: downstream (per-slave) offset width. Slave index = S_xADR[P_SLV_AWIDTH +: P_SEL_WIDTH].
- P_NUM_SLV, 4: number of downstream slaves, 1..16.
- P_SEL_WIDTH, 4: index field width. Requires P_SLV_AWIDTH + P_SEL_WIDTH <= P_ADDR_WIDTH and 2^P_SEL_WIDTH >= P_NUM_SLV.
- P_TIMEOUT, 255: maximum cycles to wait for a slave RVLD, 1..65535.
- P_ERR_DATA, 32'hDEAD_BEEF: read data returned on timeout or unmapped read.

Ports:
- CLK  in  1  clock; single clock domain.
- RST  in  1  reset, asynchronous, active-high.
- S_WREN  in  1  upstream write strobe.
- S_WADR  in  P_ADDR_WIDTH  upstream write address.
- S_WDAT  in  32  upstream write data.
- S_RDEN  in  1  upstream read strobe.
- S_RADR  in  P_ADDR_WIDTH  upstream read address.
- S_RDAT  out  32  upstream read data.
- S_RVLD  out  1  upstream read-valid pulse.
- S_BUSY  out  1  read in flight; master must not assert S_RDEN while high.
- M_WREN  out  P_NUM_SLV  per-slave write strobe.
- M_WADR  out  P_NUM_SLV*P_SLV_AWIDTH  per-slave write offset, packed, slave i at [i*P_SLV_AWIDTH +: P_SLV_AWIDTH].
- M_WDAT  out  P_NUM_SLV*32  per-slave write data, packed.
- M_RDEN  out  P_NUM_SLV  per-slave read strobe.
- M_RADR  out  P_NUM_SLV*P_SLV_AWIDTH  per-slave read offset, packed.
- M_RDAT  in  P_NUM_SLV*32  per-slave read data, packed.
- M_RVLD  in  P_NUM_SLV  per-slave read-valid.
- ERR_CLR  in  1  clears all sticky error flags.
- ERR_TO  out  1  sticky: a read timed out.
- ERR_UNMAP  out  1  sticky: a read or write targeted index >= P_NUM_SLV.
- ERR_OVF  out  1  sticky: S_RDEN was asserted while S_BUSY was high.

Behaviour:
Reset
- RST high clears all outputs to 0 asynchronously, forces the FSM to IDLE, and clears the timeout counter and all flags.
- Reset mid-transaction abandons the read with no S_RVLD. A late M_RVLD after reset is ignored.

Write path
- Fully registered, independent of the read FSM.
- S_WREN with index i < P_NUM_SLV: M_WREN[i]=1 for exactly 1 cycle, 1 cycle later, with M_WADR/M_WDAT slice i holding the offset and data.
- Unmapped index: no strobe; set ERR_UNMAP.
- Writes are accepted in any FSM state, including concurrent with reads.

Read FSM
- IDLE: on S_RDEN, latch the index into sel.
  - Mapped: go to REQ.
  - Unmapped: load P_ERR_DATA, set ERR_UNMAP, go to RESP.
- REQ: M_RDEN[sel]=1 for 1 cycle with M_RADR slice sel; clear tmo_cnt; go to WAIT.
- WAIT: tmo_cnt increments each cycle.
  - If M_RVLD[sel]=1: capture M_RDAT slice sel, go to RESP.
  - Else if tmo_cnt == P_TIMEOUT-1: load P_ERR_DATA, set ERR_TO, go to RESP.
  - If M_RVLD[sel] arrives on the timeout cycle, the valid data wins and ERR_TO is not set.
- RESP: S_RVLD=1 for 1 cycle with S_RDAT; go to IDLE.
- S_RDAT holds its last value otherwise.
- S_BUSY = (state != IDLE), registered.
- S_RDEN outside IDLE is ignored and sets ERR_OVF.
- M_RVLD from non-selected slaves, or outside WAIT, is ignored.

Latency
- Mapped read: S_RDEN at cycle t gives M_RDEN at t+1. M_RVLD[sel] at t+1+k (k>=1) gives S_RVLD at t+2+k.
- Unmapped read: S_RVLD at t+2.
- Timeout read: S_RVLD at t+2+P_TIMEOUT.

Error flags
- ERR_CLR clears all flags at the next edge.
- A set event in the same cycle as ERR_CLR wins; the flag stays 1.

Decomposition:
- Package reg_bus_pkg: state enum (IDLE, REQ, WAIT, RESP), the default error-data constant, and a function computing the slave index from an address.
- Sub-module reg_bus_decode: combinational index extraction plus mapped check, instantiated for both the write and read paths.

Test Plan:
- Write S_WADR=16'h2034, data 32'h1234_5678, N=4 → 1 cycle later only M_WREN[2]=1, M_WADR slice 2=12'h034, M_WDAT slice 2=32'h1234_5678.
- Read S_RADR=16'h1010; slave 1 returns 32'hCAFE_0001 three cycles after M_RDEN → S_RVLD with that data at t+5; S_BUSY high t+1..t+5.
- Read slave 3, which never responds, P_TIMEOUT=8 → S_RVLD at t+10 with 32'hDEAD_BEEF; ERR_TO=1; ERR_CLR pulse → ERR_TO=0.
- Write to 16'h5000 then read 16'h7000 with N=4 → no M_WREN/M_RDEN; ERR_UNMAP=1; S_RVLD at t+2 with 32'hDEAD_BEEF.
- Second S_RDEN during WAIT, plus a stray M_RVLD[0] while sel=1 → both ignored; ERR_OVF=1; the original read completes with slave 1 data.
- RST asserted during WAIT, then slave M_RVLD arrives → all outputs 0, no S_RVLD; the next read after reset completes normally.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// Shared types, constants and helpers for the register-bus splitter.
package reg_bus_pkg;

   // Read-side state machine encoding.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } rd_state_e;

   // Read data returned when a read times out or targets no slave.
   localparam logic [31:0] C_ERR_DATA = 32'hDEAD_BEEF;

   // Slave index field of an address: 'width' bits starting at bit 'lsb'.
   function automatic logic [15:0] slv_index(input logic [63:0] addr,
                                             input int unsigned lsb,
                                             input int unsigned width);
      logic [63:0] mask;
      mask = (64'd1 << width) - 64'd1;
      return 16'((addr >> lsb) & mask);
   endfunction

endpackage

// File: rtl/reg_bus_decode.sv
// Combinational address decode: one-hot slave select, slave offset and
// mapped check. Shared by the write and read paths of the splitter.
module reg_bus_decode
   import reg_bus_pkg::*;
#(
   parameter int P_ADDR_WIDTH = 16,
   parameter int P_SLV_AWIDTH = 12,
   parameter int P_NUM_SLV    = 4,
   parameter int P_SEL_WIDTH  = 4
) (
   input  logic [P_ADDR_WIDTH-1:0] addr,
   output logic [P_NUM_SLV-1:0]    sel_oh,
   output logic [P_SLV_AWIDTH-1:0] offset,
   output logic                    mapped
);

   localparam logic [P_NUM_SLV-1:0] C_ONE = P_NUM_SLV'(1'b1);

   logic [15:0] idx_s;

   // Extract the index field, flag indices beyond the last slave, build one-hot.
   always_comb begin
      idx_s  = slv_index(64'(addr), P_SLV_AWIDTH, P_SEL_WIDTH);
      offset = addr[P_SLV_AWIDTH-1:0];
      mapped = (idx_s < 16'(P_NUM_SLV));
      if (mapped) begin
         sel_oh = C_ONE << idx_s;
      end else begin
         sel_oh = {P_NUM_SLV{1'b0}};
      end
   end

endmodule

// File: rtl/reg_bus_split.sv
// 1-to-N register-bus splitter with registered write fan-out, a read FSM
// with response timeout, unmapped-address handling and sticky error flags.
module reg_bus_split
   import reg_bus_pkg::*;
#(
   parameter int          P_ADDR_WIDTH = 16,
   parameter int          P_SLV_AWIDTH = 12,
   parameter int          P_NUM_SLV    = 4,
   parameter int          P_SEL_WIDTH  = 4,
   parameter int          P_TIMEOUT    = 255,
   parameter logic [31:0] P_ERR_DATA   = C_ERR_DATA
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic                              S_WREN,
   input  logic [P_ADDR_WIDTH-1:0]           S_WADR,
   input  logic [31:0]                       S_WDAT,
   input  logic                              S_RDEN,
   input  logic [P_ADDR_WIDTH-1:0]           S_RADR,
   output logic [31:0]                       S_RDAT,
   output logic                              S_RVLD,
   output logic                              S_BUSY,
   output logic [P_NUM_SLV-1:0]              M_WREN,
   output logic [P_NUM_SLV*P_SLV_AWIDTH-1:0] M_WADR,
   output logic [P_NUM_SLV*32-1:0]           M_WDAT,
   output logic [P_NUM_SLV-1:0]              M_RDEN,
   output logic [P_NUM_SLV*P_SLV_AWIDTH-1:0] M_RADR,
   input  logic [P_NUM_SLV*32-1:0]           M_RDAT,
   input  logic [P_NUM_SLV-1:0]              M_RVLD,
   input  logic                              ERR_CLR,
   output logic                              ERR_TO,
   output logic                              ERR_UNMAP,
   output logic                              ERR_OVF
);

   localparam int          AW      = P_SLV_AWIDTH;
   localparam logic [15:0] C_TMO_L = 16'(P_TIMEOUT - 1);

   // Decoder outputs
   logic [P_NUM_SLV-1:0] w_oh_s, r_oh_s;
   logic [AW-1:0]        w_off_s, r_off_s;
   logic                 w_map_s, r_map_s;

   // Write path state
   logic [P_NUM_SLV-1:0]    wren_d, wren_q;
   logic [P_NUM_SLV*AW-1:0] wadr_d, wadr_q;
   logic [P_NUM_SLV*32-1:0] wdat_d, wdat_q;

   // Read path state
   rd_state_e               state_d, state_q;
   logic [P_NUM_SLV-1:0]    sel_d, sel_q;
   logic [P_NUM_SLV-1:0]    rden_d, rden_q;
   logic [P_NUM_SLV*AW-1:0] radr_d, radr_q;
   logic [15:0]             tmo_d, tmo_q;
   logic [31:0]             rdat_d, rdat_q;
   logic                    rvld_d, rvld_q;
   logic                    busy_d, busy_q;

   // Error flags and their set events
   logic to_d, to_q, unmap_d, unmap_q, ovf_d, ovf_q;
   logic to_set_s, unmap_rd_set_s, unmap_set_s, ovf_set_s;

   // Selected slave response
   logic        sel_vld_s;
   logic [31:0] sel_dat_s;

   reg_bus_decode #(
      .P_ADDR_WIDTH(P_ADDR_WIDTH), .P_SLV_AWIDTH(P_SLV_AWIDTH),
      .P_NUM_SLV(P_NUM_SLV), .P_SEL_WIDTH(P_SEL_WIDTH)
   ) u_wdec (
      .addr(S_WADR), .sel_oh(w_oh_s), .offset(w_off_s), .mapped(w_map_s)
   );

   reg_bus_decode #(
      .P_ADDR_WIDTH(P_ADDR_WIDTH), .P_SLV_AWIDTH(P_SLV_AWIDTH),
      .P_NUM_SLV(P_NUM_SLV), .P_SEL_WIDTH(P_SEL_WIDTH)
   ) u_rdec (
      .addr(S_RADR), .sel_oh(r_oh_s), .offset(r_off_s), .mapped(r_map_s)
   );

   // Write fan-out: one-cycle strobe to the addressed slave, its slice updated.
   always_comb begin
      wadr_d = wadr_q;
      wdat_d = wdat_q;
      if (S_WREN) begin
         wren_d = w_oh_s;
      end else begin
         wren_d = {P_NUM_SLV{1'b0}};
      end
      for (int i = 0; i < P_NUM_SLV; i++) begin
         if (S_WREN && w_oh_s[i]) begin
            wadr_d[i*AW +: AW] = w_off_s;
            wdat_d[i*32 +: 32] = S_WDAT;
         end else begin
            wadr_d[i*AW +: AW] = wadr_q[i*AW +: AW];
            wdat_d[i*32 +: 32] = wdat_q[i*32 +: 32];
         end
      end
   end

   // Pick the valid and data of the latched slave; others are ignored.
   always_comb begin
      sel_vld_s = |(M_RVLD & sel_q);
      sel_dat_s = 32'h0000_0000;
      for (int i = 0; i < P_NUM_SLV; i++) begin
         if (sel_q[i]) begin
            sel_dat_s = M_RDAT[i*32 +: 32];
         end else begin
            sel_dat_s = sel_dat_s;
         end
      end
   end

   // Read FSM next state and registered-output next values.
   // An unmapped read still spends one cycle in REQ (with no strobe, since its
   // select is empty) so that its response lands two cycles after the request.
   always_comb begin
      state_d        = state_q;
      sel_d          = sel_q;
      rden_d         = {P_NUM_SLV{1'b0}};
      radr_d         = radr_q;
      tmo_d          = tmo_q;
      rdat_d         = rdat_q;
      rvld_d         = 1'b0;
      to_set_s       = 1'b0;
      unmap_rd_set_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (S_RDEN) begin
               sel_d   = r_oh_s;
               state_d = ST_REQ;
               if (r_map_s) begin
                  rden_d = r_oh_s;
                  for (int i = 0; i < P_NUM_SLV; i++) begin
                     if (r_oh_s[i]) begin
                        radr_d[i*AW +: AW] = r_off_s;
                     end else begin
                        radr_d[i*AW +: AW] = radr_q[i*AW +: AW];
                     end
                  end
               end else begin
                  unmap_rd_set_s = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            tmo_d = 16'h0000;
            if (|sel_q) begin
               state_d = ST_WAIT;
            end else begin
               state_d = ST_RESP;
               rvld_d  = 1'b1;
               rdat_d  = P_ERR_DATA;
            end
         end
         ST_WAIT: begin
            tmo_d = tmo_q + 16'h0001;
            if (sel_vld_s) begin
               state_d = ST_RESP;
               rvld_d  = 1'b1;
               rdat_d  = sel_dat_s;
            end else if (tmo_q == C_TMO_L) begin
               state_d  = ST_RESP;
               rvld_d   = 1'b1;
               rdat_d   = P_ERR_DATA;
               to_set_s = 1'b1;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Sticky error flags: a set event in the same cycle as a clear wins.
   always_comb begin
      unmap_set_s = unmap_rd_set_s | (S_WREN & ~w_map_s);
      ovf_set_s   = S_RDEN & (state_q != ST_IDLE);
      if (ERR_CLR) begin
         to_d    = to_set_s;
         unmap_d = unmap_set_s;
         ovf_d   = ovf_set_s;
      end else begin
         to_d    = to_q | to_set_s;
         unmap_d = unmap_q | unmap_set_s;
         ovf_d   = ovf_q | ovf_set_s;
      end
   end

   // All state registers, asynchronously cleared.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wren_q  <= '0;
         wadr_q  <= '0;
         wdat_q  <= '0;
         state_q <= ST_IDLE;
         sel_q   <= '0;
         rden_q  <= '0;
         radr_q  <= '0;
         tmo_q   <= 16'h0000;
         rdat_q  <= 32'h0000_0000;
         rvld_q  <= 1'b0;
         busy_q  <= 1'b0;
         to_q    <= 1'b0;
         unmap_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         wren_q  <= wren_d;
         wadr_q  <= wadr_d;
         wdat_q  <= wdat_d;
         state_q <= state_d;
         sel_q   <= sel_d;
         rden_q  <= rden_d;
         radr_q  <= radr_d;
         tmo_q   <= tmo_d;
         rdat_q  <= rdat_d;
         rvld_q  <= rvld_d;
         busy_q  <= busy_d;
         to_q    <= to_d;
         unmap_q <= unmap_d;
         ovf_q   <= ovf_d;
      end
   end

   assign M_WREN    = wren_q;
   assign M_WADR    = wadr_q;
   assign M_WDAT    = wdat_q;
   assign M_RDEN    = rden_q;
   assign M_RADR    = radr_q;
   assign S_RDAT    = rdat_q;
   assign S_RVLD    = rvld_q;
   assign S_BUSY    = busy_q;
   assign ERR_TO    = to_q;
   assign ERR_UNMAP = unmap_q;
   assign ERR_OVF   = ovf_q;

endmodule
